// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous prefetch FIFO:
// parameter legality, count width and prefetch occupancy encoding.
package fifo_pkg;

    // Prefetch stage occupancy: head only, or head plus skid.
    // The encoding equals the number of words held.
    typedef enum logic [1:0] {
        PF_EMPTY = 2'd0,
        PF_HEAD  = 2'd1,
        PF_FULL  = 2'd2
    } pf_occ_e;

    // Word count needs one bit more than the pointers to represent "full".
    function automatic int cnt_width(input int depth_width);
        return depth_width + 1;
    endfunction

    function automatic bit params_legal(
        input int data_width,
        input int depth_width,
        input int afull_th,
        input int aempty_th
    );
        return (data_width >= 1) && (data_width <= 1152) &&
               (depth_width >= 4) && (depth_width <= 16) &&
               (afull_th >= 0) && (afull_th <= 2**depth_width) &&
               (aempty_th >= 0) && (aempty_th <= 2**depth_width);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage with a 1-cycle registered read.
// Ports: clk; wr_en/wr_addr/wr_data write side; rd_en/rd_addr in, rd_data out.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // No reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_prefetch_fifo.sv
// First-word-fall-through FIFO: block RAM plus a head/skid prefetch stage.
// Ports: sys_clk, sys_rst_n; wr_en/wr_data/wr_vld; rd_en/rd_vld/rd_data;
// data_cnt, almost_full, almost_empty; clr_err, overflow, underflow.
module sync_prefetch_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 8,
    parameter int AFULL_TH    = 2**DEPTH_WIDTH - 4,
    parameter int AEMPTY_TH   = 4
) (
    input  logic                                sys_clk,
    input  logic                                sys_rst_n,
    input  logic                                wr_en,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    output logic                                wr_vld,
    input  logic                                rd_en,
    output logic                                rd_vld,
    output logic [DATA_WIDTH-1:0]               rd_data,
    output logic [cnt_width(DEPTH_WIDTH)-1:0]   data_cnt,
    output logic                                almost_full,
    output logic                                almost_empty,
    input  logic                                clr_err,
    output logic                                overflow,
    output logic                                underflow
);

    localparam int CW = cnt_width(DEPTH_WIDTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    if (!params_legal(DATA_WIDTH, DEPTH_WIDTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
        $error("sync_prefetch_fifo: illegal parameter set");
    end

    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic                   infl;
    logic [DATA_WIDTH-1:0]  ram_q;
    logic [DATA_WIDTH-1:0]  head;
    logic [DATA_WIDTH-1:0]  skid;
    pf_occ_e                pf_occ;
    pf_occ_e                pf_nxt;
    logic [1:0]             pf_num;
    logic [1:0]             pipe_cnt;
    logic [CW-1:0]          ram_pend;
    logic [CW-1:0]          cnt_nxt;
    logic                   wr_acc;
    logic                   rd_acc;
    logic                   ram_rd;
    logic                   head_ld_ram;
    logic                   head_ld_skid;
    logic                   skid_ld;

    // Count never exceeds 2^DEPTH_WIDTH, so the MSB alone marks "full".
    assign wr_vld  = ~data_cnt[CW-1];
    assign rd_vld  = (pf_occ != PF_EMPTY);
    assign rd_data = head;

    assign wr_acc = wr_en & wr_vld;
    assign rd_acc = rd_en & rd_vld;

    // Words still sitting in RAM = total - prefetched - read in flight.
    assign pf_num   = pf_occ;
    assign pipe_cnt = pf_num + {1'b0, infl};
    assign ram_pend = data_cnt - CW'(pipe_cnt);

    // Refill when a slot is free now or is being freed by this pop;
    // the pop term is what sustains one word per cycle.
    assign ram_rd = (ram_pend != '0) &&
                    ((pipe_cnt < 2'd2) || rd_acc);

    assign cnt_nxt = data_cnt + CW'(wr_acc) - CW'(rd_acc);

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_WIDTH)
    ) u_ram (
        .clk     (sys_clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pf_occ <= PF_EMPTY;
        end else begin
            pf_occ <= pf_nxt;
        end
    end

    always_comb begin
        pf_nxt = pf_occ;
        unique case (pf_occ)
            PF_EMPTY: begin
                if (infl) pf_nxt = PF_HEAD;
            end
            PF_HEAD: begin
                if (infl && !rd_acc)      pf_nxt = PF_FULL;
                else if (!infl && rd_acc) pf_nxt = PF_EMPTY;
            end
            PF_FULL: begin
                if (!infl && rd_acc) pf_nxt = PF_HEAD;
            end
            default: pf_nxt = PF_EMPTY;
        endcase
    end

    always_comb begin
        head_ld_ram  = 1'b0;
        head_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        unique case (pf_occ)
            PF_EMPTY: begin
                head_ld_ram = infl;
            end
            PF_HEAD: begin
                head_ld_ram = infl & rd_acc;
                skid_ld     = infl & ~rd_acc;
            end
            PF_FULL: begin
                head_ld_skid = rd_acc;
                skid_ld      = infl & rd_acc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (head_ld_ram)       head <= ram_q;
            else if (head_ld_skid) head <= skid;
            if (skid_ld)           skid <= ram_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            infl         <= 1'b0;
            data_cnt     <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
            if (ram_rd) rd_ptr <= rd_ptr + DEPTH_WIDTH'(1);
            infl         <= ram_rd;
            data_cnt     <= cnt_nxt;
            almost_full  <= (cnt_nxt >= AFULL_C);
            almost_empty <= (cnt_nxt <= AEMPTY_C);
            // A new error in the clearing cycle keeps the flag set.
            overflow  <= (wr_en & ~wr_vld) | (overflow & ~clr_err);
            underflow <= (rd_en & ~rd_vld) | (underflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_sync_prefetch_fifo.sv
// Bench for sync_prefetch_fifo: directed vector table, corner sequences
// and a randomized run against a queue-based reference model.
module tb_sync_prefetch_fifo;

    localparam int DEPTH = 256;
    localparam int AF_TH = 252;
    localparam int AE_TH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic       wr_vld;
    logic       rd_vld;
    logic [7:0] rd_data;
    logic [8:0] data_cnt;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] q_data [$];
    int         q_edge [$];
    int         edge_no = 0;
    int         n_wr = 0;
    int         n_rd = 0;
    bit         m_ovf = 0;
    bit         m_unf = 0;

    sync_prefetch_fifo dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_vld       (wr_vld),
        .rd_en        (rd_en),
        .rd_vld       (rd_vld),
        .rd_data      (rd_data),
        .data_cnt     (data_cnt),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       clr;
        logic [8:0] cnt;
        logic       vld;
        logic [7:0] dat;
        logic       ovf;
        logic       unf;
    } vec_t;

    localparam int NV = 10;
    vec_t vt [NV];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // A word is visible at the head once two edges have passed since it
    // was written and every older word has been popped.
    function automatic bit m_rd_vld();
        return (q_data.size() > 0) && (edge_no - q_edge[0] >= 2);
    endfunction

    task automatic check_all();
        check("data_cnt", 32'(data_cnt), 32'(q_data.size()));
        check("cnt_vs_ops", 32'(data_cnt), 32'(n_wr - n_rd));
        check("wr_vld", 32'(wr_vld), 32'(q_data.size() < DEPTH));
        check("rd_vld", 32'(rd_vld), 32'(m_rd_vld()));
        if (m_rd_vld()) check("rd_data", 32'(rd_data), 32'(q_data[0]));
        check("almost_full", 32'(almost_full),
              32'(q_data.size() >= AF_TH));
        check("almost_empty", 32'(almost_empty),
              32'(q_data.size() <= AE_TH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // Called #1 after a rising edge; applies inputs over one edge.
    task automatic tick(input logic we, input logic [7:0] wd,
                        input logic re, input logic clr);
        bit wr_ok;
        bit rd_ok;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        clr_err = clr;
        wr_ok = we && (q_data.size() < DEPTH);
        rd_ok = re && m_rd_vld();
        @(posedge clk);
        #1;
        edge_no++;
        if (rd_ok) begin
            void'(q_data.pop_front());
            void'(q_edge.pop_front());
            n_rd++;
        end
        if (wr_ok) begin
            q_data.push_back(wd);
            q_edge.push_back(edge_no);
            n_wr++;
        end
        m_ovf = (we && !wr_ok) ? 1'b1 : (m_ovf && !clr);
        m_unf = (re && !rd_ok) ? 1'b1 : (m_unf && !clr);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        check_all();
    endtask

    // Asserts reset mid-cycle, checks outputs before any edge,
    // and releases it just after the next edge.
    task automatic do_reset();
        #2;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("rst_data_cnt", 32'(data_cnt), 32'd0);
        check("rst_wr_vld", 32'(wr_vld), 32'd1);
        check("rst_rd_vld", 32'(rd_vld), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        q_data.delete();
        q_edge.delete();
        n_wr  = 0;
        n_rd  = 0;
        m_ovf = 0;
        m_unf = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vt[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 9'd1, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 9'd1, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 9'd1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 9'd0, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[6] = '{1'b1, 8'h3C, 1'b1, 1'b0, 9'd1, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 9'd1, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 9'd1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vt[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0};

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < NV; i++) begin
            tick(vt[i].we, vt[i].wd, vt[i].re, vt[i].clr);
            check($sformatf("vec%0d_cnt", i), 32'(data_cnt), 32'(vt[i].cnt));
            check($sformatf("vec%0d_vld", i), 32'(rd_vld), 32'(vt[i].vld));
            if (vt[i].vld)
                check($sformatf("vec%0d_dat", i), 32'(rd_data), 32'(vt[i].dat));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vt[i].ovf));
            check($sformatf("vec%0d_unf", i), 32'(underflow), 32'(vt[i].unf));
        end

        // Fill to capacity with 0..255.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b1, 8'(i), 1'b0, 1'b0);
            if (i + 1 == AF_TH - 1)
                check("afull_below_th", 32'(almost_full), 32'd0);
            if (i + 1 == AF_TH)
                check("afull_at_th", 32'(almost_full), 32'd1);
        end
        check("full_wr_vld", 32'(wr_vld), 32'd0);
        check("full_cnt", 32'(data_cnt), 32'd256);
        tick(1'b1, 8'hFF, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_cnt_held", 32'(data_cnt), 32'd256);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Drain back-to-back; every cycle must present the next word.
        for (int i = 0; i < DEPTH; i++) begin
            check("pop_vld", 32'(rd_vld), 32'd1);
            check("pop_data", 32'(rd_data), 32'(i));
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drained_vld", 32'(rd_vld), 32'd0);
        check("drained_cnt", 32'(data_cnt), 32'd0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("unf_set", 32'(underflow), 32'd1);

        // Write+read at empty (with clear): write only, new error wins.
        tick(1'b1, 8'h77, 1'b1, 1'b1);
        check("empty_wr_rd_cnt", 32'(data_cnt), 32'd1);
        check("unf_set_wins", 32'(underflow), 32'd1);

        // Refill, then write+read at full: pop only.
        for (int i = 0; i < DEPTH - 1; i++)
            tick(1'b1, 8'(i + 3), 1'b0, 1'b0);
        check("refull_cnt", 32'(data_cnt), 32'd256);
        tick(1'b1, 8'hEE, 1'b1, 1'b0);
        check("full_wr_rd_cnt", 32'(data_cnt), 32'd255);
        check("full_wr_rd_ovf", 32'(overflow), 32'd1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);

        // Randomized traffic, alternating fill-biased and drain-biased phases.
        for (int c = 0; c < 10000; c++) begin
            int pw;
            pw = ((c / 700) % 2 == 0) ? 75 : 30;
            tick(($urandom_range(99) < pw) ? 1'b1 : 1'b0,
                 8'($urandom),
                 ($urandom_range(99) < (100 - pw)) ? 1'b1 : 1'b0,
                 ($urandom_range(63) == 0) ? 1'b1 : 1'b0);
        end

        // Reset with 100 words held, then a fresh write must read back.
        do_reset();
        for (int i = 0; i < 100; i++)
            tick(1'b1, 8'(i + 40), 1'b0, 1'b0);
        check("held_100", 32'(data_cnt), 32'd100);
        do_reset();
        tick(1'b1, 8'h5A, 1'b0, 1'b0);
        check("post_rst_cnt", 32'(data_cnt), 32'd1);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        check("post_rst_vld", 32'(rd_vld), 32'd1);
        check("post_rst_data", 32'(rd_data), 32'h5A);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rst_empty", 32'(data_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_prefetch_fifo.md
SYNC_PREFETCH_FIFO -- requirements
Module: sync_prefetch_fifo

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: sys_clk clocks all state; sys_rst_n asynchronously resets it.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the word width (1..1152).
REQ-003 The block SHALL have parameter DEPTH_WIDTH, default 8, giving capacity 2^DEPTH_WIDTH words (4..16).
REQ-004 The block SHALL have parameter AFULL_TH, default 2^DEPTH_WIDTH-4, giving the almost_full threshold in words.
REQ-005 The block SHALL have parameter AEMPTY_TH, default 4, giving the almost_empty threshold in words.
REQ-006 Port sys_clk SHALL be an input, 1 bit wide: the clock.
REQ-007 Port sys_rst_n SHALL be an input, 1 bit wide: asynchronous active-low reset.
REQ-008 Port wr_en SHALL be an input, 1 bit wide: write request.
REQ-009 Port wr_data SHALL be an input, DATA_WIDTH bits wide: write word.
REQ-010 Port wr_vld SHALL be an output, 1 bit wide: space available; a write is accepted when wr_en is high and wr_vld is high.
REQ-011 Port rd_en SHALL be an input, 1 bit wide: pop request.
REQ-012 Port rd_vld SHALL be an output, 1 bit wide: rd_data holds a valid head word.
REQ-013 Port rd_data SHALL be an output, DATA_WIDTH bits wide: head word, first-word-fall-through.
REQ-014 Port data_cnt SHALL be an output, DEPTH_WIDTH+1 bits wide: words held, including prefetched words.
REQ-015 Port almost_full SHALL be an output, 1 bit wide: high when data_cnt >= AFULL_TH.
REQ-016 Port almost_empty SHALL be an output, 1 bit wide: high when data_cnt <= AEMPTY_TH.
REQ-017 Port clr_err SHALL be an input, 1 bit wide: clears the sticky error flags.
REQ-018 Port overflow SHALL be an output, 1 bit wide: sticky flag for a write attempted while full.
REQ-019 Port underflow SHALL be an output, 1 bit wide: sticky flag for a read attempted while empty.

Function
REQ-020 The block SHALL accept a write when wr_en && wr_vld, and a pop when rd_en && rd_vld.
REQ-021 wr_vld SHALL equal (data_cnt < 2^DEPTH_WIDTH) and SHALL be derived from registered state only.
REQ-022 data_cnt SHALL update on the following edge by +1 for an accepted write, -1 for an accepted pop, and 0 for both or neither.
REQ-023 Writing into an empty FIFO at edge k SHALL make rd_vld high after edge k+2, with rd_data equal to that word.
REQ-024 When at least 2 words are held, consecutive pops SHALL sustain 1 word per cycle in write order; a 2-entry prefetch stage (head + skid) covers the RAM read latency.
REQ-025 rd_data SHALL stay stable while rd_vld is high and rd_en is low.
REQ-026 When full, a simultaneous wr_en and rd_en SHALL pop only; the write is rejected because wr_vld is low.
REQ-027 When empty, a simultaneous wr_en and rd_en SHALL write only; the read is rejected.
REQ-028 Read and write pointers SHALL be DEPTH_WIDTH bits and SHALL wrap modulo 2^DEPTH_WIDTH without a bubble.
REQ-029 wr_en while !wr_vld SHALL be ignored and SHALL set overflow; rd_en while !rd_vld SHALL be ignored and SHALL set underflow.
REQ-030 clr_err SHALL clear overflow and underflow on the next edge; if a new error occurs in the same cycle, the set SHALL win.
REQ-031 almost_full and almost_empty SHALL be registered and consistent with data_cnt in the same cycle.

Reset
REQ-032 On sys_rst_n low, the block SHALL immediately force data_cnt=0, wr_vld=1, rd_vld=0, rd_data=0, almost_full=0, almost_empty=1, overflow=0, underflow=0, and both pointers to 0.
REQ-033 RAM contents SHALL NOT be reset.
REQ-034 A reset mid-operation SHALL discard all held words.
REQ-035 After sys_rst_n deasserts, the block SHALL accept a write on the first edge.

Structure
REQ-036 Parameter legality checks and the count-width function SHALL reside in shared package fifo_pkg.
REQ-037 Storage SHALL be a single sub-module, sync_fifo_ram: simple dual-port, 1-cycle registered read, inferable as block RAM.
REQ-038 The prefetch/skid control, pointers, counters and flags SHALL reside in the top module.

Verification
REQ-039 The bench SHALL cover: after reset, write 0xA5 once -> rd_vld high 2 cycles later, rd_data=0xA5, data_cnt=1.
REQ-040 The bench SHALL cover: fill 256 words (0..255) with defaults -> wr_vld=0 and almost_full=1 from count 252; a 257th write sets overflow and data_cnt stays 256.
REQ-041 The bench SHALL cover: pop 256 back-to-back with rd_en held -> data 0..255 with no gaps, then rd_vld=0; an extra rd_en sets underflow.
REQ-042 The bench SHALL cover: simultaneous wr/rd at full and at empty -> data_cnt 256->255 and 0->1 respectively.
REQ-043 The bench SHALL cover: random wr_en/rd_en for 10k cycles over 3 pointer wraps -> scoreboard match, and data_cnt always equals writes minus pops.
REQ-044 The bench SHALL cover: sys_rst_n pulsed low with 100 words held -> all outputs at reset values immediately, and the next write reads back correctly.
